madd_acc_seq: RTL and testbench

- Sequencer that folds a group of N_OPS operands into one modular sum using a single external 2-input modular adder (madd_32_64).
- The adder is purely combinational; this block owns the accumulator, the operand count and the handshakes.
- Used in the HCU to build multi-operand terms such as T1 = h + Σ1 + Ch + K + W for SHA-256 (mode64=0) and SHA-512 (mode64=1).

---
 rtl/madd_acc_seq.sv | 80 ++++++++
 tb/tb_madd_acc_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/madd_acc_seq.sv
// Folds N_OPS operands into one modular sum through a shared external
// combinational adder; owns the accumulator, operand count and handshakes.
module madd_acc_seq #(
  parameter int N_OPS = 5,
  parameter int GRP_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode64,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [63:0]      op_data,
  output logic             madd_mode64,
  output logic [63:0]      madd_a,
  output logic [63:0]      madd_b,
  input  logic [63:0]      madd_s,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [63:0]      sum_data,
  output logic             sum_mode64,
  output logic             busy,
  output logic [GRP_W-1:0] grp_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  localparam logic [3:0] LAST = 4'(N_OPS - 1);

  state_e             state_q;
  logic [63:0]        acc_q;
  logic [3:0]         cnt_q;
  logic               mode_q;
  logic [GRP_W-1:0]   grp_q;
  logic [63:0]        acc_first_d;
  logic               accept;

  // First operand seeds the accumulator; in 32-bit mode the lower half is dropped.
  assign acc_first_d = mode64 ? op_data : {op_data[63:32], 32'h0};
  assign accept      = op_valid && op_ready;

  assign op_ready    = rstn && (state_q != OUT);
  assign madd_a      = acc_q;
  assign madd_b      = op_data;
  assign madd_mode64 = mode_q;
  assign sum_valid   = (state_q == OUT);
  assign sum_data    = acc_q;
  assign sum_mode64  = mode_q;
  assign busy        = (state_q != IDLE);
  assign grp_cnt     = grp_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      grp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mode_q  <= mode64;
          acc_q   <= acc_first_d;
          cnt_q   <= 4'd1;
          state_q <= (N_OPS == 1) ? OUT : ACC;
        end
        ACC: if (accept) begin
          acc_q <= madd_s;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST) state_q <= OUT;
        end
        OUT: if (sum_ready) begin
          state_q <= IDLE;
          grp_q   <= grp_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_madd_acc_seq.sv
// Directed bench for madd_acc_seq with a behavioural model of the external adder.
module tb_madd_acc_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mode64;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_data;
  logic        madd_mode64;
  logic [63:0] madd_a, madd_b, madd_s;
  logic        sum_valid;
  logic        sum_ready;
  logic [63:0] sum_data;
  logic        sum_mode64;
  logic        busy;
  logic [1:0]  grp_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  madd_acc_seq #(.N_OPS(5), .GRP_W(2)) dut (
    .clk(clk), .rstn(rstn), .mode64(mode64), .op_valid(op_valid), .op_ready(op_ready),
    .op_data(op_data), .madd_mode64(madd_mode64), .madd_a(madd_a), .madd_b(madd_b),
    .madd_s(madd_s), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_mode64(sum_mode64), .busy(busy), .grp_cnt(grp_cnt)
  );

  // External madd_32_64: full 64-bit add, or upper-half add with lower half zeroed.
  always_comb begin
    madd_s = '0;
    if (madd_mode64) madd_s = madd_a + madd_b;
    else             madd_s = {madd_a[63:32] + madd_b[63:32], 32'h0};
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic m);
    int t;
    t = 0;
    op_valid = 1'b1; op_data = d; mode64 = m;
    @(negedge clk);
    while (!op_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("push_timeout", 64'(t), 64'(0));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Waits for the sum, checks it, then handshakes with op_valid asserted
  // across the OUT->IDLE edge to prove that edge never accepts.
  task automatic take(input string tag, input logic [63:0] d, input logic m, input logic [1:0] g);
    int t;
    t = 0;
    while (!sum_valid && t < 50) begin @(posedge clk); #1; t++; end
    check({tag, "_timeout"}, 64'(t >= 50), 64'(0));
    check({tag, "_data"}, sum_data, d);
    check({tag, "_mode"}, 64'(sum_mode64), 64'(m));
    sum_ready = 1'b1; op_valid = 1'b1; op_data = 64'h1234; mode64 = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0; op_valid = 1'b0;
    check({tag, "_grp"}, 64'(grp_cnt), 64'(g));
    check({tag, "_vld_low"}, 64'(sum_valid), 64'(0));
    check({tag, "_no_handoff_accept"}, 64'(busy), 64'(0));
  endtask

  logic [31:0] sha [5] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A, 32'h510E527F};
  logic [63:0] mv  [5] = '{64'hFFFFFFFF_AAAAAAAA, 64'h00000002_55555555, 64'h10000000_FFFFFFFF,
                           64'h20000000_00000001, 64'h00000003_80000000};
  logic [1:0]  gseq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rstn = 1'b0; mode64 = 1'b0; op_valid = 1'b0; op_data = '0; sum_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_op_ready", 64'(op_ready), 64'(0));
    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sum_valid", 64'(sum_valid), 64'(0));
    check("rst_sum_data", sum_data, 64'h0);
    check("rst_grp", 64'(grp_cnt), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    check("idle_op_ready", 64'(op_ready), 64'(1));

    // SHA-256 T1-style fold, back to back, sum_ready held high throughout
    sum_ready = 1'b1;
    for (int i = 0; i < 5; i++) push({sha[i], 32'($urandom())}, 1'b0);
    check("sha_latency", 64'(sum_valid), 64'(1));
    check("sha_out_op_ready", 64'(op_ready), 64'(0));
    take("sha", 64'h583ED017_00000000, 1'b0, 2'd1);

    // 64-bit mode wraparound
    for (int i = 0; i < 5; i++) push(64'hFFFFFFFF_FFFFFFFF, 1'b1);
    take("ones64", 64'hFFFFFFFF_FFFFFFFB, 1'b1, 2'd2);

    // Random valid gaps, then a 10-cycle output stall with op_valid held
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 sum_ready = 1'b1;
      push({sha[i], 32'($urandom())}, 1'b0);
      sum_ready = 1'b0;
    end
    check("gap_latency", 64'(sum_valid), 64'(1));
    op_valid = 1'b1; op_data = 64'hDEAD_BEEF_0000_0001; mode64 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall_op_ready", 64'(op_ready), 64'(0));
      check("stall_data", sum_data, 64'h583ED017_00000000);
    end
    op_valid = 1'b0;
    take("gap", 64'h583ED017_00000000, 1'b0, 2'd3);

    // Mode fixed by first operand; later operands ask for 64-bit mode
    push(mv[0], 1'b0);
    for (int i = 1; i < 5; i++) push(mv[i], 1'b1);
    take("modefix", 64'h30000004_00000000, 1'b0, 2'd0);

    // Reset mid-group discards partial sum and clears the group counter
    for (int i = 0; i < 3; i++) push(64'h1111_1111_1111_1111, 1'b1);
    rstn = 1'b0; op_valid = 1'b1;
    #1 check("rstmid_op_ready", 64'(op_ready), 64'(0));
    @(posedge clk); #1;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_sum_valid", 64'(sum_valid), 64'(0));
    check("rstmid_grp", 64'(grp_cnt), 64'(0));
    check("rstmid_data", sum_data, 64'h0);
    op_valid = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;
    check("rstmid_no_sum", 64'(sum_valid), 64'(0));

    // Five groups after reset: counter wraps 1,2,3,0,1
    for (int g = 0; g < 5; g++) begin
      for (int i = 1; i <= 5; i++) push(64'(g * 16 + i), 1'b1);
      take("grp", 64'(g * 80 + 15), 1'b1, gseq[g]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
